// File: rtl/pmem_scheduler.sv
// Single-port physical-memory arbiter between the I-cache (read) and D-cache (read/write).
// D-cache wins contention until it has taken MAX_DSTREAK contended grants in a row.
`timescale 1ns/1ps
module pmem_scheduler #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          icache_pmem_read,
  input  logic [15:0]   icache_pmem_address,
  input  logic          dcache_pmem_read,
  input  logic          dcache_pmem_write,
  input  logic [15:0]   dcache_pmem_address,
  input  logic [127:0]  dcache_pmem_wdata,
  input  logic          pmem_resp,
  output logic          icache_pmem_resp,
  output logic          dcache_pmem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  output logic          ld_regs
);

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_e;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DSTREAK);

  state_e        state_q, state_d;
  logic [2:0]    dstreak_q, dstreak_d;
  logic [15:0]   addr_q, addr_d;
  logic [127:0]  wdata_q, wdata_d;
  logic          d_req, any_req, d_wins;

  assign d_req   = dcache_pmem_read | dcache_pmem_write;
  assign any_req = d_req | icache_pmem_read;
  assign d_wins  = d_req & ~(icache_pmem_read & (dstreak_q == STREAK_MAX));

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d = dcache_pmem_write ? D_WRITE : D_READ;
          addr_d  = dcache_pmem_address;
          if (dcache_pmem_write) wdata_d = dcache_pmem_wdata;
          if (icache_pmem_read && dstreak_q < STREAK_MAX) dstreak_d = dstreak_q + 3'd1;
        end else if (icache_pmem_read) begin
          state_d   = I_READ;
          addr_d    = icache_pmem_address;
          dstreak_d = 3'd0;
        end
      end
      I_READ, D_READ, D_WRITE: if (pmem_resp) state_d = DONE;
      // turnaround cycle gives the finished cache time to drop its request
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dstreak_q <= 3'd0;
      addr_q    <= 16'h0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign pmem_read        = (state_q == I_READ) | (state_q == D_READ);
  assign pmem_write       = (state_q == D_WRITE);
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign icache_pmem_resp = (state_q == I_READ) & pmem_resp;
  assign dcache_pmem_resp = ((state_q == D_READ) | (state_q == D_WRITE)) & pmem_resp;
  assign ld_regs          = (state_q == IDLE) & ~any_req;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Bench for pmem_scheduler: directed timing scenarios plus a randomized run against a
// transaction-level arbitration model.
`timescale 1ns/1ps
module tb_pmem_scheduler;
  localparam int MAXD = 4;
  localparam logic [127:0] LINE = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_pmem_read, dcache_pmem_read, dcache_pmem_write, pmem_resp;
  logic [15:0]   icache_pmem_address, dcache_pmem_address;
  logic [127:0]  dcache_pmem_wdata;
  logic          icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write, ld_regs;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [4:0]    obs;

  int n_tests = 0;
  int n_fail  = 0;

  pmem_scheduler #(.MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .reset(reset),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .pmem_resp(pmem_resp),
    .icache_pmem_resp(icache_pmem_resp), .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .ld_regs(ld_regs)
  );

  always #5 clk = ~clk;

  // {pmem_read, pmem_write, icache_resp, dcache_resp, ld_regs}
  assign obs = {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp, ld_regs};

  task automatic idle_inputs();
    icache_pmem_read  = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    pmem_resp         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    icache_pmem_address = 16'h0; dcache_pmem_address = 16'h0; dcache_pmem_wdata = '0;
    reset = 1'b1;
    #2;
    n_tests++;
    if (obs !== 5'b00001 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs obs=%b addr=%h wdata=%h expected obs=00001 addr=0 wdata=0",
               obs, pmem_address, pmem_wdata);
    end
    icache_pmem_read = 1'b1; pmem_resp = 1'b1;
    #1;
    n_tests++;
    if (obs !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ld_with_req obs=%b expected 00000", obs);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    step(); step();
    #3;
    n_tests++;
    if (obs !== 5'b00001) begin
      n_fail++; $display("FAIL post_reset_idle obs=%b expected 00001", obs);
    end
  endtask

  task automatic test_icache_read();
    logic [4:0] exp;
    icache_pmem_address = 16'h1230;
    for (int c = 0; c <= 6; c++) begin
      step();
      icache_pmem_read = (c <= 4);
      pmem_resp        = (c == 4);
      #3;
      exp = {(c >= 1 && c <= 4), 1'b0, (c == 4), 1'b0, (c >= 6)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL icache_read cyc%0d obs=%b expected %b", c, obs, exp);
      end
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if (pmem_address !== 16'h1230) begin
          n_fail++; $display("FAIL icache_addr cyc%0d addr=%h expected 1230", c, pmem_address);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_priority_write();
    logic [4:0] exp;
    icache_pmem_address = 16'h0040;
    for (int c = 0; c <= 9; c++) begin
      step();
      icache_pmem_read    = (c <= 7);
      dcache_pmem_write   = (c <= 3);
      dcache_pmem_address = (c == 0) ? 16'h8000 : 16'($urandom);
      dcache_pmem_wdata   = (c == 0) ? LINE : {$urandom, $urandom, $urandom, $urandom};
      pmem_resp           = (c == 3 || c == 7);
      #3;
      exp = {(c >= 6 && c <= 7), (c >= 1 && c <= 3), (c == 7), (c == 3), (c == 9)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL prio_write cyc%0d obs=%b expected %b", c, obs, exp);
      end
      if (c >= 1 && c <= 3) begin
        n_tests++;
        if (pmem_address !== 16'h8000 || pmem_wdata !== LINE) begin
          n_fail++;
          $display("FAIL prio_write_data cyc%0d addr=%h wdata=%h expected addr=8000 wdata=%h",
                   c, pmem_address, pmem_wdata, LINE);
        end
      end
      if (c >= 6 && c <= 7) begin
        n_tests++;
        if (pmem_address !== 16'h0040) begin
          n_fail++; $display("FAIL prio_iread_addr cyc%0d addr=%h expected 0040", c, pmem_address);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    int  got;
    bit  exp_i;
    got = 0;
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h0100;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0200;
    pmem_resp = 1'b1;
    for (int c = 0; c < 80 && got < 2 * (MAXD + 1); c++) begin
      step();
      #3;
      if (icache_pmem_resp || dcache_pmem_resp) begin
        exp_i = ((got % (MAXD + 1)) == MAXD);
        n_tests++;
        if (icache_pmem_resp !== exp_i || dcache_pmem_resp !== !exp_i) begin
          n_fail++;
          $display("FAIL starve_order grant%0d iresp=%b dresp=%b expected iresp=%b dresp=%b",
                   got, icache_pmem_resp, dcache_pmem_resp, exp_i, !exp_i);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 2 * (MAXD + 1)) begin
      n_fail++; $display("FAIL starve_timeout grants=%0d expected %0d", got, 2 * (MAXD + 1));
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h4444;
    step(); step();
    #3;
    n_tests++;
    if (obs !== 5'b10000) begin
      n_fail++; $display("FAIL rst_mid_pre obs=%b expected 10000", obs);
    end
    step();
    pmem_resp = 1'b1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs !== 5'b00000 || pmem_address !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_async obs=%b addr=%h expected obs=00000 addr=0", obs, pmem_address);
    end
    idle_inputs();
    #1;
    n_tests++;
    if (obs !== 5'b00001) begin
      n_fail++; $display("FAIL rst_mid_released obs=%b expected 00001", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    #3;
    n_tests++;
    if (obs !== 5'b00001) begin
      n_fail++; $display("FAIL rst_mid_after obs=%b expected 00001", obs);
    end
  endtask

  task automatic test_spurious_resp();
    logic [4:0] exp;
    idle_inputs();
    pmem_resp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #3;
      n_tests++;
      if (obs !== 5'b00001) begin
        n_fail++; $display("FAIL spurious_idle cyc%0d obs=%b expected 00001", c, obs);
      end
    end
    dcache_pmem_address = 16'hA5A0;
    for (int c = 0; c <= 4; c++) begin
      step();
      dcache_pmem_write = (c <= 1);
      dcache_pmem_wdata = {4{$urandom}};
      #3;
      case (c)
        0:       exp = 5'b00000;
        1:       exp = 5'b01010;
        2:       exp = 5'b00000;
        default: exp = 5'b00001;
      endcase
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL spurious_done cyc%0d obs=%b expected %b", c, obs, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold_through_done();
    logic [4:0] exp;
    dcache_pmem_address = 16'h3C00;
    for (int c = 0; c <= 6; c++) begin
      step();
      dcache_pmem_read = (c <= 4);
      pmem_resp        = (c == 1 || c == 4);
      #3;
      case (c)
        1, 4:    exp = 5'b10010;
        6:       exp = 5'b00001;
        default: exp = 5'b00000;
      endcase
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL hold_done cyc%0d obs=%b expected %b", c, obs, exp);
      end
    end
    idle_inputs();
  endtask

  // Model: one transaction in flight at a time, one dead cycle after each completion,
  // and a count of contended data grants since the last instruction grant.
  task automatic test_random();
    bit            m_busy, m_turn, m_own_i, m_wr;
    int            m_streak;
    logic [15:0]   m_addr;
    logic [127:0]  m_wdata;
    logic [4:0]    exp;
    bit            d_req, any_req;
    int            k;
    idle_inputs();
    step();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_busy = 0; m_turn = 0; m_own_i = 0; m_wr = 0; m_streak = 0;
    m_addr = 16'h0; m_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      if (m_busy) begin
        if (pmem_resp) begin m_busy = 0; m_turn = 1; end
      end else if (m_turn) begin
        m_turn = 0;
      end else begin
        d_req = dcache_pmem_read || dcache_pmem_write;
        if (d_req && !(icache_pmem_read && m_streak == MAXD)) begin
          m_busy = 1; m_own_i = 0; m_wr = dcache_pmem_write; m_addr = dcache_pmem_address;
          if (dcache_pmem_write) m_wdata = dcache_pmem_wdata;
          if (icache_pmem_read && m_streak < MAXD) m_streak++;
        end else if (icache_pmem_read) begin
          m_busy = 1; m_own_i = 1; m_wr = 0; m_addr = icache_pmem_address; m_streak = 0;
        end
      end
      #1;
      icache_pmem_read    = ($urandom_range(0, 9) < 7);
      k                   = $urandom_range(0, 9);
      dcache_pmem_read    = (k < 4);
      dcache_pmem_write   = (k >= 4 && k < 7);
      icache_pmem_address = 16'($urandom);
      dcache_pmem_address = 16'($urandom);
      dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp           = ($urandom_range(0, 9) < 4);
      #3;
      any_req = icache_pmem_read || dcache_pmem_read || dcache_pmem_write;
      exp = {m_busy && !m_wr, m_busy && m_wr, m_busy && m_own_i && pmem_resp,
             m_busy && !m_own_i && pmem_resp, !m_busy && !m_turn && !any_req};
      n_tests++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random_ctrl cyc%0d obs=%b expected %b", c, obs, exp);
      end
      if (m_busy) begin
        n_tests++;
        if (pmem_address !== m_addr) begin
          n_fail++; $display("FAIL random_addr cyc%0d addr=%h expected %h", c, pmem_address, m_addr);
        end
      end
      if (m_busy && m_wr) begin
        n_tests++;
        if (pmem_wdata !== m_wdata) begin
          n_fail++; $display("FAIL random_wdata cyc%0d wdata=%h expected %h", c, pmem_wdata, m_wdata);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_icache_read();
    test_priority_write();
    test_starvation();
    test_reset_mid();
    test_spurious_resp();
    test_hold_through_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmem_scheduler.md
# pmem_scheduler

Arbitrates the single physical-memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined LC-3b core. It latches one request at a time, runs that request's physical-memory transaction to completion and returns the response to the owning cache. It also produces `ld_regs`, which gates every pipeline latch load. Data cache has priority, with a bounded-starvation guarantee for the instruction cache.

## Interface
- `MAX_DSTREAK`, default 4: consecutive contended data-cache grants allowed before the instruction cache is forced ahead. Legal range 1..7.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `icache_pmem_read`  in  1  instruction-cache line fill request.
- `icache_pmem_address`  in  16  line address (lc3b_word).
- `dcache_pmem_read`  in  1  data-cache line fill request.
- `dcache_pmem_write`  in  1  data-cache line write-back request; never asserted together with `dcache_pmem_read`.
- `dcache_pmem_address`  in  16  line address.
- `dcache_pmem_wdata`  in  128  write-back line (lc3b_c_block).
- `pmem_resp`  in  1  physical memory done; single-cycle pulse.
- `icache_pmem_resp`  out  1  completion pulse to the instruction cache.
- `dcache_pmem_resp`  out  1  completion pulse to the data cache.
- `pmem_read`  out  1  physical-memory read.
- `pmem_write`  out  1  physical-memory write.
- `pmem_address`  out  16  physical-memory address.
- `pmem_wdata`  out  128  physical-memory write data.
- `ld_regs`  out  1  pipeline latch load enable.

## Operation
- States: IDLE, I_READ, D_READ, D_WRITE, DONE. Reset enters IDLE.
- IDLE: arbitrate among the requests present this cycle.
  - Only icache requesting: go to I_READ.
  - Only dcache requesting: go to D_READ or D_WRITE, according to its request type.
  - Both requesting: dcache wins unless `dstreak == MAX_DSTREAK`, in which case icache wins.
  - No request: stay in IDLE.
- On the grant edge:
  - Latch `addr_q` from the winner's address.
  - Latch `wdata_q` from `dcache_pmem_wdata` (D_WRITE only).
- I_READ / D_READ / D_WRITE:
  - Drive `pmem_address = addr_q`.
  - Hold `pmem_read` high (read states) or `pmem_write` high with `pmem_wdata = wdata_q` (D_WRITE) until `pmem_resp`.
  - While `pmem_resp` is high, drive the owner's `*_pmem_resp` combinationally for that cycle, then go to DONE.
  - The non-owner's resp output stays 0.
  - Requester inputs are ignored while busy.
- DONE: one mandatory turnaround cycle, during which no grant is made. This lets the finished cache drop its request. Next state is IDLE.
- `dstreak` (3-bit):
  - Resets to 0.
  - Cleared on every icache grant.
  - Incremented, saturating at `MAX_DSTREAK`, on a dcache grant where `icache_pmem_read` was also high.
  - Unchanged on an uncontended dcache grant.
- `ld_regs` = 1 only when state is IDLE and no `*_pmem_read/write` input is high; otherwise 0.
- Outputs at and during reset: `pmem_read`, `pmem_write`, both resp outputs = 0. `pmem_address` and `pmem_wdata` = 0, because `addr_q` and `wdata_q` reset to 0. `ld_regs` follows its combinational rule (1 if no requests).
- Reset asserted mid-transaction: abandon immediately to IDLE with all strobes low. Memory is expected to be reset as well.
- `pmem_resp` outside the three transfer states is ignored.

## Timing
- A request seen high in IDLE during cycle 0 produces `pmem_read`/`pmem_write` high from cycle 1.
- With `pmem_resp` in cycle k ≥ 1:
  - Owner resp is high in cycle k only.
  - Strobes drop in cycle k+1 (DONE).
  - IDLE in cycle k+2; the earliest next grant is decided in cycle k+2 with strobes in k+3.
- Back-to-back transactions are therefore separated by exactly 2 idle strobe cycles.
- A request arriving during DONE is not granted before IDLE.
- `pmem_address` and `pmem_wdata` are stable for the entire strobe window, even if the requester changes its inputs.

## Test plan
- Icache-only read at address 0x1230, `pmem_resp` 3 cycles after strobe:
  - `pmem_read` high for cycles 1..4 with address 0x1230.
  - `icache_pmem_resp` pulses in cycle 4; `dcache_pmem_resp` stays 0.
  - `ld_regs` 0 from cycle 0 through 5.
- Simultaneous icache read 0x0040 and dcache write 0x8000 with data 0xDEAD…BEEF:
  - D_WRITE first, with `pmem_wdata` equal to the latched line even if the input is changed mid-write.
  - Then I_READ at 0x0040.
- Starvation, `MAX_DSTREAK=4`: dcache re-requests continuously while icache holds its request. Exactly 4 dcache grants, then an icache grant, and `dstreak` returns to 0.
- Reset asserted while in D_READ: strobes drop asynchronously, state is IDLE, no resp is issued, and `ld_regs` = 1 once requests are released.
- Spurious `pmem_resp` in IDLE or DONE: no resp outputs and no state change.
- Request held through DONE with the requester not dropping it: re-granted on the IDLE cycle after DONE, never earlier.
